// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_muldiv_seq_if                                                |
// | Brief   : Request/result bundle between the EX-stage controller and ALU.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  ready, done, out, hi, lo, zero, overflow, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, out, hi, lo, zero, overflow, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_muldiv_seq                                                   |
// | Brief   : Registered ALU with iterative multiply/divide and HI/LO results. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_muldiv_seq_if.slave  bus
);
    localparam logic [4:0] c_op_add   = 5'b00000;
    localparam logic [4:0] c_op_sub   = 5'b00001;
    localparam logic [4:0] c_op_slt   = 5'b00010;
    localparam logic [4:0] c_op_and   = 5'b00011;
    localparam logic [4:0] c_op_nor   = 5'b00100;
    localparam logic [4:0] c_op_or    = 5'b00101;
    localparam logic [4:0] c_op_xor   = 5'b00110;
    localparam logic [4:0] c_op_sll   = 5'b00111;
    localparam logic [4:0] c_op_srl   = 5'b01000;
    localparam logic [4:0] c_op_sltu  = 5'b01001;
    localparam logic [4:0] c_op_sllv  = 5'b01100;
    localparam logic [4:0] c_op_sra   = 5'b01101;
    localparam logic [4:0] c_op_srav  = 5'b01110;
    localparam logic [4:0] c_op_srlv  = 5'b01111;
    localparam logic [4:0] c_op_lui   = 5'b10000;
    localparam logic [4:0] c_op_mult  = 5'b10001;
    localparam logic [4:0] c_op_multu = 5'b10010;
    localparam logic [4:0] c_op_div   = 5'b10011;
    localparam logic [4:0] c_op_divu  = 5'b10100;
    localparam logic [4:0] c_op_mfhi  = 5'b10101;
    localparam logic [4:0] c_op_mflo  = 5'b10110;

    localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dbz;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [SHW-1:0]   r_cnt;
    logic             r_is_div;
    logic             r_dz;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic [SHW-1:0]     w_sh;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_sum     = bus.a + bus.b;
    assign w_diff    = bus.a - bus.b;
    assign w_sh      = bus.a[SHW-1:0];
    assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1]  != bus.a[WIDTH-1]);
    assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);

    always_comb begin
        w_res = '0;
        case (bus.op)
            c_op_add:             w_res = w_sum;
            c_op_sub:             w_res = w_diff;
            c_op_slt:             w_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            c_op_and:             w_res = bus.a & bus.b;
            c_op_nor:             w_res = ~(bus.a | bus.b);
            c_op_or:              w_res = bus.a | bus.b;
            c_op_xor:             w_res = bus.a ^ bus.b;
            c_op_sll, c_op_sllv:  w_res = bus.b << w_sh;
            c_op_srl, c_op_srlv:  w_res = bus.b >> w_sh;
            c_op_sltu:            w_res = WIDTH'(bus.a < bus.b);
            c_op_sra, c_op_srav:  w_res = $unsigned($signed(bus.b) >>> w_sh);
            c_op_lui:             w_res = bus.b << (WIDTH / 2);
            c_op_mfhi:            w_res = r_hi;
            c_op_mflo:            w_res = r_lo;
            default:              w_res = '0;
        endcase
    end

    // Iterative unit works on magnitudes; signs are re-applied in FIN.
    assign w_is_mul = (bus.op == c_op_mult) || (bus.op == c_op_multu);
    assign w_is_div = (bus.op == c_op_div)  || (bus.op == c_op_divu);
    assign w_signed = (bus.op == c_op_mult) || (bus.op == c_op_div);
    assign w_a_neg  = w_signed && bus.a[WIDTH-1];
    assign w_b_neg  = w_signed && bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    assign w_b_zero = (bus.b == '0);

    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : '0);
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_d};
    // The shifted remainder is below 2*divisor, so the MSB of the difference is a clean borrow.
    assign w_div_ge    = ~w_div_diff[WIDTH];

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo      = r_neg_q ? (~r_q + 1'b1)    : r_q;
    assign w_rem      = r_neg_r ? (~r_acc + 1'b1)  : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_out    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_is_mul || w_is_div) begin
                            r_is_div <= w_is_div;
                            r_dz     <= w_is_div && w_b_zero;
                            r_q      <= w_a_mag;
                            r_d      <= w_b_mag;
                            // A zero-divisor op parks the dividend here for hi.
                            r_acc    <= (w_is_div && w_b_zero) ? bus.a : '0;
                            r_cnt    <= '0;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_ready  <= 1'b0;
                            r_state  <= (w_is_div && w_b_zero) ? S_FIN : S_CALC;
                        end else begin
                            r_out  <= w_res;
                            r_zero <= (w_res == '0);
                            r_done <= 1'b1;
                            if (bus.op == c_op_add) begin
                                r_ovf <= w_add_ovf;
                            end else if (bus.op == c_op_sub) begin
                                r_ovf <= w_sub_ovf;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_dz) begin
                        r_hi  <= r_acc;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi  <= w_rem;
                        r_lo  <= w_quo;
                        r_dbz <= 1'b0;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = r_ready;
    assign bus.done        = r_done;
    assign bus.out         = r_out;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.zero        = r_zero;
    assign bus.overflow    = r_ovf;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Registered, parametrised successor of the single-cycle datapath ALU.
- Executes all single-cycle ALU ops with one-cycle latency.
- Adds an iterative multiply/divide unit with HI/LO result registers, a start/ready/done handshake, and overflow detection for both add and sub.
- Sits in the EX stage; the controller stalls on ready=0.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, at least 8.
- SHW, $clog2(WIDTH), shift-amount width taken from a[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch op; accepted only when ready=1
- op  in  5  operation code, sampled with start
- a  in  WIDTH  operand A (shift amount for shifts)
- b  in  WIDTH  operand B
- ready  out  1  unit idle, can accept start
- done  out  1  one-cycle pulse, result valid
- out  out  WIDTH  registered general result
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)
- zero  out  1  out==0, registered with out
- overflow  out  1  signed overflow of the last add/sub
- div_by_zero  out  1  last div/divu had b==0

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, ready=1.
  - done, out, hi, lo, overflow, div_by_zero = 0.
  - zero=1.
  - Iteration counter and partial registers cleared.
- States:
  - IDLE: ready=1.
  - CALC: ready=0, iterating.
  - FIN: ready=0; writes hi/lo and pulses done; next state IDLE.
- Accept: start=1 while ready=1 latches op, a, b. start while ready=0 is ignored; no queuing.
- Single-cycle ops, IDLE->IDLE. out is written at the edge after accept, with done=1 that same cycle; latency 1.
  - 00000 add; 00001 sub; 00010 slt (signed); 00011 and; 00100 nor; 00101 or; 00110 xor.
  - 00111 sll b<<a[SHW-1:0]; 01000 srl; 01001 sltu; 01010/01011 out=0.
  - 01100 sllv; 01101/01110 sra (arithmetic); 01111 srlv; 10000 lui b<<(WIDTH/2).
  - 10101 mfhi out=hi; 10110 mflo out=lo.
  - Undefined codes: out=0, done still pulses.
- Overflow rules:
  - overflow is updated only by add/sub; all other ops hold it.
  - add: set when sign(a)==sign(b) and sign(sum)!=sign(a).
  - sub: set when sign(a)!=sign(b) and sign(diff)!=sign(a).
  - out always takes the wrapped result.
- Multi-cycle ops, IDLE->CALC for exactly WIDTH cycles ->FIN:
  - 10001 mult, 10010 multu, 10011 div, 10100 divu.
  - done is asserted WIDTH+1 cycles after the accept edge.
  - out and zero hold their previous values through mult/div.
- Multiply: radix-2 shift-add on magnitudes; signed mult negates the 2*WIDTH result when sign(a)^sign(b). {hi,lo} = full product.
- Divide: restoring, on magnitudes.
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Signed MIN/-1 gives lo=MIN, hi=0, no flag.
- Divide by zero (b==0 on div/divu):
  - Skip CALC: IDLE->FIN, done 1 cycle after accept.
  - hi=a, lo=all ones, div_by_zero=1.
  - div_by_zero is cleared by the next accepted div/divu with b!=0 and held by all other ops.
- hi/lo change only in FIN; mfhi/mflo issued after done see the new values.
- done is never asserted in IDLE without a preceding accept.

Test Plan:
- Reset: assert rst mid-CALC of a mult -> same cycle ready=1, done=0, hi=lo=0, zero=1; a following add starts normally.
- add a=0x7FFFFFFF, b=1 -> next cycle out=0x80000000, overflow=1, done=1. Then sub a=0x80000000, b=1 -> out=0x7FFFFFFF, overflow=1. Then sub 5-5 -> out=0, zero=1, overflow=0.
- mult a=0xFFFFFFFF (-1), b=7 -> ready low for 33 cycles; done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF9. Same operands with multu -> hi=6, lo=0xFFFFFFF9.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2. Then mflo -> out=14 after 1 cycle.
- div b=0, a=0x1234 -> done 1 cycle after accept; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. Then divu 9/3 -> div_by_zero=0.
- start pulsed on every cycle during a 33-cycle divu -> extra starts ignored, exactly one done; sra b=0x80000000, a=4 afterwards -> out=0xF8000000.
